// File: rtl/simple_ram_unit.sv
// Word-addressed 32-bit backing store with fixed access latency.
// Any change on {data, addr, wr} starts a new operation; state=1 means idle/done.
module simple_ram_unit #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        state,
  output logic [31:0] q
);

  // state   | meaning
  // ST_BUSY | request latched, latency timer running
  // ST_IDLE | last operation complete, waiting for an input change
  typedef enum logic {
    ST_BUSY = 1'b0,
    ST_IDLE = 1'b1
  } ram_state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  ram_state_t        state_q, state_d;
  logic [31:0]       data_l, data_l_d;
  logic [31:0]       addr_l, addr_l_d;
  logic              wr_l, wr_l_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              req_chg;
  logic              done;
  logic              mem_we;
  logic              rd_done;
  logic [ADDR_W-1:0] idx;

  logic [31:0] mem [DEPTH] = '{default: '0};

  assign idx     = addr_l[ADDR_W-1:0];
  assign req_chg = ({data, addr, wr} != {data_l, addr_l, wr_l});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_l  <= '0;
      addr_l  <= '0;
      wr_l    <= 1'b0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      data_l  <= data_l_d;
      addr_l  <= addr_l_d;
      wr_l    <= wr_l_d;
      cnt     <= cnt_d;
    end
  end

  // The timer counts down from LATENCY-1; completion fires on the edge it sits at zero.
  always_comb begin
    state_d  = state_q;
    data_l_d = data_l;
    addr_l_d = addr_l;
    wr_l_d   = wr_l;
    cnt_d    = cnt;
    done     = 1'b0;
    if (req_chg) begin
      state_d  = ST_BUSY;
      data_l_d = data;
      addr_l_d = addr;
      wr_l_d   = wr;
      cnt_d    = CNT_LOAD;
    end else begin
      case (state_q)
        ST_BUSY: begin
          if (cnt == '0) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign mem_we  = done && wr_l;
  assign rd_done = done && !wr_l;

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= data_l;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (rd_done) q <= mem[idx];
  end

  assign state = state_q;

endmodule

// File: tb/tb_simple_ram_unit.sv
// Scoreboard bench for simple_ram_unit: expected q/latency queued at drive time,
// compared when state returns high.
module tb_simple_ram_unit;

  localparam int ADDR_W  = 8;
  localparam int LATENCY = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic [31:0] addr;
  logic        wr;
  logic        state;
  logic [31:0] q;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [1 << ADDR_W];
  logic [31:0] ref_q;
  logic [31:0] exp_q [$];

  simple_ram_unit #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .addr  (addr),
    .wr    (wr),
    .state (state),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] a, input logic w);
    data = d;
    addr = a;
    wr   = w;
  endtask

  // Drive a request that runs to completion, queue its expected q, then compare.
  task automatic do_op(input string tag, input logic [31:0] d, input logic [31:0] a,
                       input logic w);
    int low_cycles;
    logic [31:0] e;
    drive(d, a, w);
    if (w) ref_mem[a[ADDR_W-1:0]] = d;
    else ref_q = ref_mem[a[ADDR_W-1:0]];
    exp_q.push_back(ref_q);
    low_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state) break;
      low_cycles++;
    end
    chk({tag, "_lat"}, low_cycles, LATENCY);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_q"}, q, e);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = '0;
    ref_q = '0;
    rst_n = 1'b0;
    drive('0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Inputs at zero after reset: no request ever detected.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_state", {31'd0, state}, 32'd1);
      chk("idle_q", q, 32'd0);
    end

    do_op("wr5", 32'hDEADBEEF, 32'd5, 1'b1);
    do_op("rd5", 32'hDEADBEEF, 32'd5, 1'b0);

    // Identical request re-presented: nothing happens.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("same_req_state", {31'd0, state}, 32'd1);
    end
    chk("same_req_q", q, 32'hDEADBEEF);

    do_op("rd6", 32'd0, 32'd6, 1'b0);

    // Abort: write to 7 redirected to 8 two cycles in.
    drive(32'h12345678, 32'd7, 1'b1);
    repeat (2) @(negedge clk);
    chk("abort_pending", {31'd0, state}, 32'd0);
    do_op("wr8", 32'h12345678, 32'd8, 1'b1);
    do_op("rd7", 32'd0, 32'd7, 1'b0);
    do_op("rd8", 32'd0, 32'd8, 1'b0);

    // Aliasing modulo 2^ADDR_W; an upper-bit-only change is still a new request.
    do_op("wr103", 32'hA5A5A5A5, 32'h103, 1'b1);
    do_op("rd003", 32'hA5A5A5A5, 32'h003, 1'b0);
    do_op("rd203", 32'hA5A5A5A5, 32'h203, 1'b0);

    // Reset during a pending write to 9.
    drive(32'h55, 32'd9, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_pending", {31'd0, state}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_state", {31'd0, state}, 32'd1);
    chk("rst_async_q", q, 32'd0);
    drive('0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_q = '0;
    @(negedge clk);
    chk("post_rst_state", {31'd0, state}, 32'd1);
    do_op("rd9", 32'd0, 32'd9, 1'b0);
    do_op("rd5_keep", 32'd0, 32'd5, 1'b0);

    // Randomised read/write mix against the reference memory.
    for (int i = 0; i < 20; i++) begin
      logic [31:0] d;
      logic [31:0] a;
      logic        w;
      d = $urandom;
      a = $urandom_range(0, 15) + (($urandom_range(0, 1) == 1) ? 32'h100 : 32'h0);
      w = ($urandom_range(0, 1) == 1);
      if (d == data && a == addr && w == wr) d = d ^ 32'h1;
      do_op("rand", d, a, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
